led_event_scheduler: RTL and testbench

LED_EVENT_SCHEDULER -- requirements
Module: led_event_scheduler

---
 rtl/led_event_scheduler.sv | 169 ++++++++++++++++
 tb/tb_led_event_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_event_scheduler.sv
// led_event_scheduler: latches rising-edge events from NUM_REQ requesters and
// serves them round-robin on one shared LED. Requester k is shown as a code of
// k+1 flashes (ON_CYCLES lit, GAP_CYCLES dark between flashes), followed by a
// SEP_CYCLES dark separator.
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous, active-low
//   req       - event lines; a rising edge on bit k is one event
//   led       - shared indicator, lit only while flashing
//   busy      - high whenever a code is in progress
//   active_id - requester being served, 0 when idle
//   pending   - latched events not yet served
//   dropped   - saturating count of events coalesced into a pending bit
module led_event_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ON_CYCLES  = 1_000_000,
  parameter int unsigned GAP_CYCLES = 500_000,
  parameter int unsigned SEP_CYCLES = 2_000_000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic               led,
  output logic               busy,
  output logic [2:0]         active_id,
  output logic [NUM_REQ-1:0] pending,
  output logic [7:0]         dropped
);

  localparam int unsigned ID_W = 3;
  localparam int unsigned FL_W = 4;

  // A zero duration still occupies one clock.
  localparam int unsigned ON_D  = (ON_CYCLES  == 0) ? 1 : ON_CYCLES;
  localparam int unsigned GAP_D = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int unsigned SEP_D = (SEP_CYCLES == 0) ? 1 : SEP_CYCLES;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_D - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_D - 1);
  localparam logic [CNT_W-1:0] SEP_LOAD = CNT_W'(SEP_D - 1);

  typedef enum logic [1:0] {IDLE, ON, GAP, SEP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   timer, timer_nx;
  logic [FL_W-1:0]    flash_left, flash_left_nx;
  logic [ID_W-1:0]    last_grant, last_grant_nx;
  logic [ID_W-1:0]    active_id_nx;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending_nx;
  logic [NUM_REQ-1:0] edge_det;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] drop_bits;
  logic [7:0]         dropped_nx;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;

  // Round-robin pick: first pending bit at or above last_grant+1, wrapping.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (state == IDLE) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(last_grant) + 1 + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_vld && ((pending & (NUM_REQ'(1) << idx)) != '0)) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
  end

  // Event latching; an edge on the bit being granted re-arms it without a drop.
  always_comb begin
    int unsigned sum;
    edge_det   = req & ~req_q;
    grant_mask = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
    drop_bits  = edge_det & pending & ~grant_mask;
    pending_nx = (pending & ~grant_mask) | edge_det;
    sum        = 32'(dropped) + 32'($countones(drop_bits));
    dropped_nx = (sum > 255) ? 8'd255 : 8'(sum);
  end

  // Next-state and sequencing of flashes within a code.
  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    flash_left_nx = flash_left;
    active_id_nx  = active_id;
    last_grant_nx = last_grant;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nx      = ON;
          timer_nx      = ON_LOAD;
          flash_left_nx = FL_W'(grant_id) + FL_W'(1);
          active_id_nx  = grant_id;
          last_grant_nx = grant_id;
        end
      end
      ON: begin
        if (timer == '0) begin
          flash_left_nx = flash_left - FL_W'(1);
          if (flash_left_nx != '0) begin
            state_nx = GAP;
            timer_nx = GAP_LOAD;
          end else begin
            state_nx = SEP;
            timer_nx = SEP_LOAD;
          end
        end else begin
          timer_nx = timer - CNT_W'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          state_nx = ON;
          timer_nx = ON_LOAD;
        end else begin
          timer_nx = timer - CNT_W'(1);
        end
      end
      SEP: begin
        if (timer == '0) begin
          state_nx     = IDLE;
          active_id_nx = '0;
        end else begin
          timer_nx = timer - CNT_W'(1);
        end
      end
      default: begin
        state_nx     = IDLE;
        active_id_nx = '0;
      end
    endcase
  end

  // State and registered outputs; reset also seeds req history to drop edges.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      flash_left <= '0;
      active_id  <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_q      <= req;
      pending    <= '0;
      dropped    <= '0;
      led        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      flash_left <= flash_left_nx;
      active_id  <= active_id_nx;
      last_grant <= last_grant_nx;
      req_q      <= req;
      pending    <= pending_nx;
      dropped    <= dropped_nx;
      led        <= (state_nx == ON);
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_led_event_scheduler.sv
// tb_led_event_scheduler: directed scenarios plus randomized traffic, every
// clock compared against a reference model that tracks each code as a start
// offset and derives the LED pattern arithmetically from the code length.
module tb_led_event_scheduler;

  localparam int N    = 4;
  localparam int ONC  = 4;
  localparam int GAPC = 2;
  localparam int SEPC = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       led;
  logic       busy;
  logic [2:0] active_id;
  logic [3:0] pending;
  logic [7:0] dropped;

  always #5 clock = ~clock;

  led_event_scheduler #(
    .NUM_REQ(N), .ON_CYCLES(ONC), .GAP_CYCLES(GAPC), .SEP_CYCLES(SEPC), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .led(led), .busy(busy),
    .active_id(active_id), .pending(pending), .dropped(dropped)
  );

  int n_vec = 0;
  int n_err = 0;
  int led_hi = 0;

  // Reference model state.
  logic [3:0] m_req_q;
  logic [3:0] m_pend;
  int         m_drop;
  bit         m_busy;
  int         m_id;
  int         m_off;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int code_len(input int k);
    return (k + 1) * ONC + k * GAPC + SEPC;
  endfunction

  function automatic bit exp_led();
    if (!m_busy) return 1'b0;
    if (m_off >= code_len(m_id) - SEPC) return 1'b0;
    return (m_off % (ONC + GAPC)) < ONC;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic rst, input logic [3:0] r);
    logic [3:0] e;
    logic [3:0] g;
    bit found;
    int k;
    if (!rst) begin
      m_req_q = r; m_pend = '0; m_drop = 0; m_busy = 0;
      m_id = 0; m_off = 0; m_last = N - 1;
    end else begin
      e = r & ~m_req_q;
      g = '0;
      if (m_busy) begin
        m_off++;
        if (m_off >= code_len(m_id)) begin
          m_busy = 0;
          m_id   = 0;
        end
      end else if (m_pend != '0) begin
        found = 0;
        for (int s = 1; s <= N; s++) begin
          k = (m_last + s) % N;
          if (!found && m_pend[k]) begin
            found  = 1;
            g[k]   = 1'b1;
            m_busy = 1;
            m_id   = k;
            m_off  = 0;
            m_last = k;
          end
        end
      end
      for (int b = 0; b < N; b++)
        if (e[b] && m_pend[b] && !g[b] && m_drop < 255) m_drop++;
      m_pend  = (m_pend & ~g) | e;
      m_req_q = r;
    end
  endtask

  task automatic tick(input logic rst, input logic [3:0] r);
    @(negedge clock);
    reset = rst;
    req   = r;
    model_step(rst, r);
    @(posedge clock);
    #1;
    led_hi += int'(led);
    check("led",       32'(led),       32'(exp_led()));
    check("busy",      32'(busy),      32'(m_busy));
    check("active_id", 32'(active_id), m_busy ? 32'(m_id) : 32'd0);
    check("pending",   32'(pending),   32'(m_pend));
    check("dropped",   32'(dropped),   32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 4'b0000);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] flip;
    bit rst;
    reset = 1'b0;
    req   = 4'b0000;

    // Reset state.
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0000);
    check("rst_led", 32'(led), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    // Single pulse on req[0]: one 4-clock flash then separator.
    led_hi = 0;
    tick(1'b1, 4'b0001);
    idle(15);
    check("s0_led_clocks", 32'(led_hi), 32'd4);
    check("s0_busy_end", 32'(busy), 32'd0);
    check("s0_dropped", 32'(dropped), 32'd0);

    // Single pulse on req[2]: three flashes.
    led_hi = 0;
    tick(1'b1, 4'b0100);
    idle(25);
    check("s2_led_clocks", 32'(led_hi), 32'd12);

    // req[1] and req[3] together from reset: 2 flashes then 4 flashes.
    tick(1'b0, 4'b0000);
    led_hi = 0;
    tick(1'b1, 4'b1010);
    idle(60);
    check("s13_led_clocks", 32'(led_hi), 32'd24);
    check("s13_pending", 32'(pending), 32'd0);

    // Three pulses on req[1], two landing inside its own code.
    tick(1'b0, 4'b0000);
    led_hi = 0;
    tick(1'b1, 4'b0010);
    idle(2);
    tick(1'b1, 4'b0010);
    idle(2);
    tick(1'b1, 4'b0010);
    idle(40);
    check("s1x3_led_clocks", 32'(led_hi), 32'd16);
    check("s1x3_dropped", 32'(dropped), 32'd1);

    // req[0] held high for 50 clocks is one event.
    tick(1'b0, 4'b0000);
    led_hi = 0;
    for (int i = 0; i < 50; i++) tick(1'b1, 4'b0001);
    idle(20);
    check("hold_led_clocks", 32'(led_hi), 32'd4);

    // Reset during the second flash of a req[3] code.
    tick(1'b0, 4'b0000);
    tick(1'b1, 4'b1000);
    idle(8);
    check("s3_in_flash2", 32'(led), 32'd1);
    tick(1'b0, 4'b0000);
    check("s3_rst_led", 32'(led), 32'd0);
    check("s3_rst_busy", 32'(busy), 32'd0);
    led_hi = 0;
    idle(40);
    check("s3_no_resume", 32'(led_hi), 32'd0);

    // Dense toggling drives dropped into saturation.
    tick(1'b0, 4'b0000);
    for (int i = 0; i < 300; i++) tick(1'b1, (i % 2 == 0) ? 4'b1111 : 4'b0000);
    check("drop_saturate", 32'(dropped), 32'd255);

    // Randomized traffic with occasional reset.
    tick(1'b0, 4'b0000);
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
      r   = r ^ flip;
      rst = ($urandom_range(0, 299) != 0);
      tick(rst, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
